// File: rtl/b_predictor_tournament.sv
// b_predictor_tournament
//   Tournament branch predictor: a per-branch local-history predictor, a gshare
//   global predictor and a 2-bit chooser, all built from 2-bit saturating
//   counters. Queries are combinational by tag. Updates are registered and
//   arrive from the resolve stage over a valid/ready handshake. After reset or
//   flush, an init sweep clears every table before traffic is accepted.
//
//   Ports
//     clk        clock, all state on posedge
//     rst        synchronous active-high reset
//     flush      restart the table-clear sweep
//     ready      tables valid; queries meaningful, updates accepted
//     tag_q      query tag
//     t_out      predicted taken (0 while !ready)
//     upd_valid  update request
//     upd_ready  equals ready
//     tag_in     tag of the resolved branch
//     t_in       resolved direction, 1 = taken
//     wack       one-cycle pulse in the cycle after an accepted update
module b_predictor_tournament #(
    parameter int unsigned TAG_LEN     = 10,
    parameter int unsigned LOCAL_HLEN  = 8,
    parameter int unsigned GLOBAL_HLEN = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    output logic               ready,
    input  logic [TAG_LEN-1:0] tag_q,
    output logic               t_out,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [TAG_LEN-1:0] tag_in,
    input  logic               t_in,
    output logic               wack
);

    localparam int unsigned MAXW_LG = (TAG_LEN > LOCAL_HLEN) ? TAG_LEN : LOCAL_HLEN;
    localparam int unsigned MAXW    = (MAXW_LG > GLOBAL_HLEN) ? MAXW_LG : GLOBAL_HLEN;
    localparam int unsigned LH_DEPTH = 1 << TAG_LEN;
    localparam int unsigned LP_DEPTH = 1 << LOCAL_HLEN;
    localparam int unsigned GP_DEPTH = 1 << GLOBAL_HLEN;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e                 state_q, state_d;
    logic [MAXW-1:0]        idx_q, idx_d;
    logic [GLOBAL_HLEN-1:0] ghist_q;
    logic                   wack_q;

    logic [LOCAL_HLEN-1:0]  lhist_q   [LH_DEPTH];
    logic [1:0]             lpht_q    [LP_DEPTH];
    logic [1:0]             gpht_q    [GP_DEPTH];
    logic [1:0]             chooser_q [GP_DEPTH];

    logic                   accept;

    // Query-side signals
    logic [MAXW-1:0]        q_ext;
    logic [GLOBAL_HLEN-1:0] q_gidx;
    logic [LOCAL_HLEN-1:0]  q_lh;

    // Update-side signals
    logic [MAXW-1:0]        u_ext;
    logic [GLOBAL_HLEN-1:0] u_gidx;
    logic [LOCAL_HLEN-1:0]  u_lh;
    logic [1:0]             u_lcnt, u_gcnt, u_ccnt;
    logic                   u_lp, u_gp;

    function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'd1;
        else    return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (flush) begin
            state_d = ST_INIT;
            idx_d   = '0;
        end else if (state_q == ST_INIT) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == '1) state_d = ST_RUN;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready     = (state_q == ST_RUN);
        upd_ready = (state_q == ST_RUN);
    end

    // A flush or reset in the same cycle wins over an update.
    assign accept = upd_valid && ready && !flush && !rst;
    assign wack   = wack_q;

    // ---------------- Query (combinational) ----------------
    // Tags are zero-extended to MAXW and then cut to GLOBAL_HLEN, which covers
    // both the truncating and the zero-extending case.
    always_comb begin
        q_ext  = MAXW'(tag_q);
        q_gidx = ghist_q ^ q_ext[GLOBAL_HLEN-1:0];
        q_lh   = lhist_q[tag_q];
        t_out  = ready & (chooser_q[q_gidx][1] ? gpht_q[q_gidx][1] : lpht_q[q_lh][1]);
    end

    // ---------------- Update lookups (pre-write state) ----------------
    always_comb begin
        u_ext  = MAXW'(tag_in);
        u_gidx = ghist_q ^ u_ext[GLOBAL_HLEN-1:0];
        u_lh   = lhist_q[tag_in];
        u_lcnt = lpht_q[u_lh];
        u_gcnt = gpht_q[u_gidx];
        u_ccnt = chooser_q[u_gidx];
        u_lp   = u_lcnt[1];
        u_gp   = u_gcnt[1];
    end

    // ---------------- Table storage ----------------
    // Tables carry no reset: the init sweep rewrites one entry of each table
    // per cycle, skipping tables shallower than the current index.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT && !rst && !flush) begin
            if (32'(idx_q) < LH_DEPTH) lhist_q[idx_q[TAG_LEN-1:0]] <= '0;
            if (32'(idx_q) < LP_DEPTH) lpht_q[idx_q[LOCAL_HLEN-1:0]] <= 2'b01;
            if (32'(idx_q) < GP_DEPTH) begin
                gpht_q[idx_q[GLOBAL_HLEN-1:0]]    <= 2'b01;
                chooser_q[idx_q[GLOBAL_HLEN-1:0]] <= 2'b01;
            end
        end else if (accept) begin
            lhist_q[tag_in] <= {u_lh[LOCAL_HLEN-2:0], t_in};
            lpht_q[u_lh]    <= sat2(u_lcnt, t_in);
            gpht_q[u_gidx]  <= sat2(u_gcnt, t_in);
            // Chooser moves only when exactly one predictor was right.
            if ((u_lp == t_in) != (u_gp == t_in))
                chooser_q[u_gidx] <= sat2(u_ccnt, u_gp == t_in);
        end
    end

    // ---------------- Global history and ack ----------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ghist_q <= '0;
            wack_q  <= 1'b0;
        end else begin
            if (accept) ghist_q <= {ghist_q[GLOBAL_HLEN-2:0], t_in};
            wack_q <= accept;
        end
    end

endmodule
